msrv_32_imm_adder_unit: RTL and testbench

MSRV_32_IMM_ADDER_UNIT -- requirements
Module: msrv_32_imm_adder

---
 rtl/msrv_32_imm_adder_unit.sv | 60 ++++++
 tb/tb_msrv_32_imm_adder_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/msrv_32_imm_adder_unit.sv
// Immediate/base adder for branch, jump and load/store target addresses.
// Provides a combinational sum and flags, plus a valid-qualified registered copy.
module msrv_32_imm_adder_unit (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] rs_1_in,
  input  logic        iadder_src_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic [31:0] iadder_out,
  output logic        iadder_carry_out,
  output logic        iadder_misaligned_out,
  output logic [31:0] iadder_out_q,
  output logic        iadder_misaligned_q,
  output logic        valid_out
);

  logic [31:0] base;
  logic [32:0] sum;

  logic [31:0] sum_q, sum_d;
  logic        misaligned_q, misaligned_d;
  logic        valid_q, valid_d;

  assign base = iadder_src_in ? rs_1_in : pc_in;
  assign sum  = {1'b0, base} + {1'b0, imm_in};

  // Bit 0 is left intact; the JALR consumer is responsible for masking it.
  assign iadder_out            = sum[31:0];
  assign iadder_carry_out      = sum[32];
  assign iadder_misaligned_out = |sum[1:0];

  always_comb begin
    sum_d        = sum_q;
    misaligned_d = misaligned_q;
    valid_d      = valid_in;
    if (valid_in) begin
      sum_d        = sum[31:0];
      misaligned_d = |sum[1:0];
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      sum_q        <= 32'h0;
      misaligned_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      misaligned_q <= misaligned_d;
      valid_q      <= valid_d;
    end
  end

  assign iadder_out_q        = sum_q;
  assign iadder_misaligned_q = misaligned_q;
  assign valid_out           = valid_q;

endmodule

// File: tb/tb_msrv_32_imm_adder_unit.sv
// Self-checking bench: directed address cases followed by random operands,
// compared against a plain-arithmetic model of the adder and its capture stage.
module tb_msrv_32_imm_adder_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1, imm, pc;
  logic        src, vin;
  logic [31:0] iadder_out, iadder_out_q;
  logic        carry, mis, mis_q, vout;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected registered state, built from what was presented at each edge.
  logic [31:0] exp_q;
  logic        exp_mis_q, exp_vout;

  always #5 clk = ~clk;

  msrv_32_imm_adder_unit dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_in  (rst),
    .rs_1_in               (rs1),
    .iadder_src_in         (src),
    .imm_in                (imm),
    .pc_in                 (pc),
    .valid_in              (vin),
    .iadder_out            (iadder_out),
    .iadder_carry_out      (carry),
    .iadder_misaligned_out (mis),
    .iadder_out_q          (iadder_out_q),
    .iadder_misaligned_q   (mis_q),
    .valid_out             (vout)
  );

  task automatic check_val(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_sum();
    longint unsigned b, s;
    b = src ? rs1 : pc;
    s = b + longint'(imm);
    return s[32:0];
  endfunction

  task automatic check_comb(input string tag);
    logic [32:0] s;
    s = ref_sum();
    #1;
    check_val({tag, "_sum"},   {1'b0, iadder_out}, {1'b0, s[31:0]});
    check_val({tag, "_carry"}, {32'b0, carry},     {32'b0, s[32]});
    check_val({tag, "_mis"},   {32'b0, mis},       {32'b0, (s % 4) != 0});
  endtask

  // One clock edge with the currently driven inputs, then check the registers.
  task automatic cycle(input string tag);
    logic [32:0] s;
    s = ref_sum();
    @(posedge clk);
    if (rst) begin
      exp_q = 32'h0; exp_mis_q = 1'b0; exp_vout = 1'b0;
    end else begin
      if (vin) begin
        exp_q = s[31:0]; exp_mis_q = (s % 4) != 0;
      end
      exp_vout = vin;
    end
    #1;
    $display("[TB] %s rst=%0b v=%0b src=%0b sum=%h q=%h vout=%0b", tag, rst, vin, src, iadder_out, iadder_out_q, vout);
    check_val({tag, "_q"},     {1'b0, iadder_out_q}, {1'b0, exp_q});
    check_val({tag, "_mis_q"}, {32'b0, mis_q},       {32'b0, exp_mis_q});
    check_val({tag, "_vout"},  {32'b0, vout},        {32'b0, exp_vout});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vin = 1'b1; src = 1'b0;
    rs1 = 32'h0; imm = 32'h0; pc = 32'h0;
    exp_q = 32'h0; exp_mis_q = 1'b0; exp_vout = 1'b0;
    @(negedge clk);
    cycle("reset");

    // Reset and valid together with live operands: registers clear, sum stays live.
    pc = 32'h1234_5670; imm = 32'h0000_0011; vin = 1'b1;
    cycle("rst_prio");
    check_val("rst_live_sum", {1'b0, iadder_out}, {1'b0, 32'h1234_5681});
    rst = 1'b0; vin = 1'b0;
    cycle("idle_after_rst");

    rs1 = 32'hAABB_CCDD; imm = 32'h1234_5678; src = 1'b1;
    check_comb("rs1_add");
    check_val("rs1_const", {carry, iadder_out}, {1'b0, 32'hBCF0_2355});
    check_val("rs1_mis", {32'b0, mis}, 33'd1);

    src = 1'b0; pc = 32'h0001_0000;
    check_comb("pc_a");
    check_val("pc_a_const", {1'b0, iadder_out}, {1'b0, 32'h1235_5678});
    imm = 32'h8765_4321;
    check_comb("pc_b");
    check_val("pc_b_const", {1'b0, iadder_out}, {1'b0, 32'h8766_4321});
    pc = 32'h0002_0000;
    check_comb("pc_c");
    check_val("pc_c_const", {1'b0, iadder_out}, {1'b0, 32'h8767_4321});

    pc = 32'hFFFF_FFFF; imm = 32'h0000_0001;
    check_comb("wrap");
    check_val("wrap_const", {carry, iadder_out}, {1'b1, 32'h0});

    pc = 32'h0000_1000; imm = 32'hFFFF_FFFC; vin = 1'b1;
    check_comb("neg_off");
    check_val("neg_const", {carry, iadder_out}, {1'b1, 32'h0000_0FFC});
    cycle("capture");
    check_val("capture_const", {1'b0, iadder_out_q}, {1'b0, 32'h0000_0FFC});
    vin = 1'b0; pc = 32'h0000_2003;
    cycle("hold");
    check_val("hold_const", {vout, iadder_out_q}, {1'b0, 32'h0000_0FFC});

    // Random operands, valid and occasional mid-stream reset.
    for (int i = 0; i < 200; i++) begin
      rs1 = $urandom; pc = $urandom; src = $urandom_range(0, 1);
      imm = ($urandom_range(0, 3) == 0) ? -$urandom_range(1, 4096) : $urandom;
      vin = $urandom_range(0, 1);
      rst = ($urandom_range(0, 15) == 0);
      check_comb("rnd");
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
